// File: rtl/hr_demux_pkg.sv
// Shared types and constants for the 1:4 receive deserializer and its
// word-alignment FSM.
package hr_demux_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

    localparam logic [3:0] SYNC_WORD_DEF = 4'b1100;
    localparam int         CNT_W         = 4;

    // Serial arrival order -> dout bit index, undoing the transmit interleave.
    function automatic logic [1:0] map_idx(input logic [1:0] ser_pos);
        logic [1:0] idx;
        case (ser_pos)
            2'd0:    idx = 2'd0;
            2'd1:    idx = 2'd2;
            2'd2:    idx = 2'd1;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // ser[i] is the i-th received bit of the word (ser[0] arrives first).
    function automatic logic [3:0] map_word(input logic [3:0] ser);
        logic [3:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            w[map_idx(2'(i))] = ser[i];
        end
        return w;
    endfunction

endpackage

// File: rtl/hr_demux_align_fsm.sv
// Bit-slip word alignment: compares received words against the training
// word, requests slips while searching and tracks lock.
//
// state  | meaning
// SEARCH | no alignment; each mismatching word requests one bit slip
// CHECK  | one or more consecutive matches seen, counting towards lock
// LOCKED | aligned; consecutive mismatches counted towards loss of lock
module hr_demux_align_fsm
    import hr_demux_pkg::*;
#(
    parameter logic [3:0] SYNC_WORD  = SYNC_WORD_DEF,
    parameter int         LOCK_CNT   = 4,
    parameter int         UNLOCK_CNT = 2
) (
    input  logic       clk_b,
    input  logic       rst_n,
    input  logic [3:0] dout,
    input  logic       dout_valid,
    input  logic       train_en,
    input  logic       slip,
    input  logic       slip_now,
    output logic       fsm_slip,
    output logic       locked
);

    localparam logic [CNT_W-1:0] LOCK_C   = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] UNLOCK_C = CNT_W'(UNLOCK_CNT);

    align_state_t     state, state_nxt;
    logic [CNT_W-1:0] match_cnt, match_nxt;
    logic [CNT_W-1:0] miss_cnt, miss_nxt;
    logic             blank, blank_nxt;
    logic             slip_req;
    logic             eval;
    logic             is_match;

    // The first word after any slip straddles the old boundary, so skip it.
    assign blank_nxt = slip_now ? 1'b1 : (dout_valid ? 1'b0 : blank);
    assign eval      = dout_valid && train_en && !blank;
    assign is_match  = (dout == SYNC_WORD);

    always_comb begin
        state_nxt = state;
        match_nxt = match_cnt;
        miss_nxt  = miss_cnt;
        slip_req  = 1'b0;
        if (slip && (state != SEARCH)) begin
            state_nxt = SEARCH;
            match_nxt = '0;
            miss_nxt  = '0;
        end else if (eval) begin
            case (state)
                SEARCH: begin
                    if (is_match) begin
                        if (LOCK_C == CNT_W'(1)) begin
                            state_nxt = LOCKED;
                            match_nxt = '0;
                        end else begin
                            state_nxt = CHECK;
                            match_nxt = CNT_W'(1);
                        end
                    end else begin
                        slip_req = 1'b1;
                    end
                end
                CHECK: begin
                    if (is_match) begin
                        if (match_cnt + CNT_W'(1) == LOCK_C) begin
                            state_nxt = LOCKED;
                            match_nxt = '0;
                        end else begin
                            match_nxt = match_cnt + CNT_W'(1);
                        end
                    end else begin
                        state_nxt = SEARCH;
                        match_nxt = '0;
                        slip_req  = 1'b1;
                    end
                end
                LOCKED: begin
                    if (is_match) begin
                        miss_nxt = '0;
                    end else if (miss_cnt + CNT_W'(1) == UNLOCK_C) begin
                        state_nxt = SEARCH;
                        miss_nxt  = '0;
                    end else begin
                        miss_nxt = miss_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = SEARCH;
                    match_nxt = '0;
                    miss_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            match_cnt <= '0;
            miss_cnt  <= '0;
            blank     <= 1'b0;
            fsm_slip  <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state     <= state_nxt;
            match_cnt <= match_nxt;
            miss_cnt  <= miss_nxt;
            blank     <= blank_nxt;
            fsm_slip  <= slip_req;
            locked    <= (state_nxt == LOCKED);
        end
    end

endmodule

// File: rtl/hr_1t4_demux_top.sv
// Receive-side 1:4 deserializer: bit sampling, word framing, divided word
// clock and slip merge around the alignment FSM.
module hr_1t4_demux_top
    import hr_demux_pkg::*;
#(
    parameter logic [3:0] SYNC_WORD  = SYNC_WORD_DEF,
    parameter int         LOCK_CNT   = 4,
    parameter int         UNLOCK_CNT = 2
) (
    input  logic       clk_b,
    input  logic       rst_n,
    input  logic       din,
    input  logic       train_en,
    input  logic       slip,
    output logic [3:0] dout,
    output logic       dout_valid,
    output logic       clk_word,
    output logic       locked
);

    logic [2:0] shreg;
    logic [1:0] cnt, cnt_nxt;
    logic       fsm_slip;
    logic       slip_now;
    logic       capture;

    // External and FSM requests in the same cycle collapse into one slip.
    assign slip_now = slip | fsm_slip;
    assign capture  = (cnt == 2'd3) && !slip_now;
    assign cnt_nxt  = slip_now ? cnt : cnt + 2'd1;

    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            cnt        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            clk_word   <= 1'b0;
        end else begin
            shreg      <= {shreg[1:0], din};
            cnt        <= cnt_nxt;
            dout_valid <= capture;
            clk_word   <= ~cnt_nxt[1];
            // shreg[2] holds the oldest bit, din the newest.
            if (capture) begin
                dout <= map_word({din, shreg[0], shreg[1], shreg[2]});
            end
        end
    end

    hr_demux_align_fsm #(
        .SYNC_WORD  (SYNC_WORD),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) u_align (
        .clk_b      (clk_b),
        .rst_n      (rst_n),
        .dout       (dout),
        .dout_valid (dout_valid),
        .train_en   (train_en),
        .slip       (slip),
        .slip_now   (slip_now),
        .fsm_slip   (fsm_slip),
        .locked     (locked)
    );

endmodule

// File: tb/tb_hr_1t4_demux_top.sv
// Scoreboard bench for the 1:4 deserializer: framing, word mapping, word
// clock, alignment lock/unlock, slip merge and asynchronous reset.
module tb_hr_1t4_demux_top;
    import hr_demux_pkg::*;

    logic       clk_b = 1'b0;
    logic       rst_n;
    logic       din;
    logic       train_en;
    logic       slip;
    logic [3:0] dout;
    logic       dout_valid;
    logic       clk_word;
    logic       locked;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [3:0] sbq[$];
    bit  sb_en     = 1'b0;
    bit  gap_chk   = 1'b1;
    bit  clk_chk   = 1'b1;
    bit  chk_first = 1'b0;
    int  rel_cyc   = 0;
    int  last_v    = -1;
    int  slips5    = 0;

    hr_1t4_demux_top dut (
        .clk_b      (clk_b),
        .rst_n      (rst_n),
        .din        (din),
        .train_en   (train_en),
        .slip       (slip),
        .dout       (dout),
        .dout_valid (dout_valid),
        .clk_word   (clk_word),
        .locked     (locked)
    );

    always #5 clk_b = ~clk_b;
    always @(posedge clk_b) cyc++;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Independent model of the interleave: s[0] is the first bit on the wire.
    function automatic logic [3:0] exp_map(input logic [3:0] s);
        return {s[3], s[1], s[2], s[0]};
    endfunction

    // Monitor: pops the scoreboard on each valid word and checks word timing.
    always @(negedge clk_b) begin
        if (!rst_n) begin
            last_v = -1;
        end else begin
            if (dout_valid) begin
                if (chk_first) begin
                    chk("first_word_latency", cyc - rel_cyc, 4);
                    chk_first = 1'b0;
                end
                if (last_v >= 0) begin
                    if (cyc - last_v == 5) slips5++;
                    if (gap_chk) chk("valid_gap", cyc - last_v, 4);
                end
                last_v = cyc;
                if (sb_en) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_word", int'(dout), -1);
                    end else begin
                        chk("word", int'(dout), int'(sbq.pop_front()));
                    end
                end
            end
            if (clk_chk && last_v >= 0) begin
                chk("clk_word", int'(clk_word), ((cyc - last_v) % 4) < 2 ? 1 : 0);
            end
        end
    end

    task automatic send_word(input logic [3:0] sbits, input logic [3:0] exp, input bit push);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_b);
            din  = sbits[k];
            slip = 1'b0;
            if (k == 1 && !push) sb_en = 1'b0;
            if (k == 3 && push) begin
                sb_en = 1'b1;
                sbq.push_back(exp);
            end
        end
    endtask

    localparam logic [3:0] GOOD = 4'b1010;  // serial 0,1,0,1 -> dout 4'b1100
    localparam logic [3:0] BAD  = 4'b1111;

    logic [3:0] tbl_s[6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0110, 4'b1010};
    logic [3:0] tbl_e[6] = '{4'b0001, 4'b0100, 4'b0010, 4'b1000, 4'b0110, 4'b1100};
    logic [3:0] pay[6]   = '{4'h3, 4'h9, 4'hE, 4'h0, 4'h7, 4'h5};

    initial begin
        int         lock_at;
        int         vi[$];
        logic [19:0] ck;
        logic [4:0] pat;

        rst_n = 1'b0; din = 1'b0; train_en = 1'b0; slip = 1'b0;
        lock_at = -1; ck = '0;

        // Reset held with din toggling.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_b);
            din = ~din;
            chk("rst_dout", int'(dout), 0);
            chk("rst_valid", int'(dout_valid), 0);
            chk("rst_clk_word", int'(clk_word), 0);
            chk("rst_locked", int'(locked), 0);
        end
        @(posedge clk_b);
        #2;
        rst_n = 1'b1; rel_cyc = cyc; chk_first = 1'b1;

        // Serial 1,0,1,1 then a table of hand-mapped words.
        send_word(4'b1101, 4'b1011, 1'b1);
        for (int t = 0; t < 6; t++) send_word(tbl_s[t], tbl_e[t], 1'b1);

        // Training stream one bit off the word boundary: one slip, then lock.
        for (int i = 0; i < 29; i++) begin
            @(negedge clk_b);
            if (locked && lock_at < 0) lock_at = i;
            din = (i % 2 == 0) ? 1'b1 : 1'b0;
            if (i == 1) begin
                train_en = 1'b1; sb_en = 1'b0; gap_chk = 1'b0; clk_chk = 1'b0; slips5 = 0;
            end
        end
        chk("lock_cycle", lock_at, 26);
        chk("lock_slips", slips5, 1);

        // Loss of lock after two consecutive bad words.
        gap_chk = 1'b1; clk_chk = 1'b1;
        send_word(BAD, exp_map(BAD), 1'b1);
        send_word(GOOD, exp_map(GOOD), 1'b1);
        chk("one_miss_locked", int'(locked), 1);
        chk("one_miss_cnt", int'(dut.u_align.miss_cnt), 1);
        send_word(GOOD, exp_map(GOOD), 1'b1);
        chk("miss_cleared", int'(dut.u_align.miss_cnt), 0);
        send_word(BAD, exp_map(BAD), 1'b1);
        send_word(BAD, exp_map(BAD), 1'b1);
        chk("first_bad_locked", int'(locked), 1);
        send_word(GOOD, exp_map(GOOD), 1'b1);
        chk("unlock_locked", int'(locked), 0);
        chk("unlock_state", int'(dut.u_align.state), int'(SEARCH));
        for (int t = 0; t < 4; t++) send_word(GOOD, exp_map(GOOD), 1'b1);
        chk("relock", int'(locked), 1);

        // Payload with train_en=0: no slips, lock held.
        train_en = 1'b0; slips5 = 0;
        for (int t = 0; t < 6; t++) send_word(pay[t], exp_map(pay[t]), 1'b1);
        chk("payload_locked", int'(locked), 1);
        chk("payload_slips", slips5, 0);

        // External slip in LOCKED, then one coincident with the FSM slip.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_b);
            if (i >= 1 && dout_valid) vi.push_back(i);
            ck[i] = clk_word;
            if (i == 1) chk("pre_slip_locked", int'(locked), 1);
            if (i == 2) begin
                chk("ext_slip_unlock", int'(locked), 0);
                chk("ext_slip_state", int'(dut.u_align.state), int'(SEARCH));
            end
            din  = 1'b1;
            slip = (i == 1) || (vi.size() == 2 && i == vi[1] + 1);
            if (i == 1) begin
                sb_en = 1'b0; gap_chk = 1'b0; clk_chk = 1'b0; train_en = 1'b1; slips5 = 0;
            end
        end
        slip = 1'b0;
        chk("slip_words_seen", (vi.size() >= 3) ? 1 : 0, 1);
        if (vi.size() >= 3) begin
            chk("ext_slip_gap", vi[0], 5);
            chk("merged_slip_gap", vi[2] - vi[1], 5);
            pat = {ck[vi[1]], ck[vi[1] + 1], ck[vi[1] + 2], ck[vi[1] + 3], ck[vi[1] + 4]};
            chk("clk_word_stretch", int'(pat), int'(5'b11100));
        end
        chk("slip_count", slips5, 2);

        // Asynchronous reset mid-word, then normal framing.
        @(negedge clk_b);
        #1 rst_n = 1'b0;
        #1;
        chk("async_dout", int'(dout), 0);
        chk("async_valid", int'(dout_valid), 0);
        chk("async_clk_word", int'(clk_word), 0);
        chk("async_locked", int'(locked), 0);
        train_en = 1'b0;
        repeat (3) @(negedge clk_b);
        @(posedge clk_b);
        #2;
        rst_n = 1'b1; rel_cyc = cyc; chk_first = 1'b1; gap_chk = 1'b1; clk_chk = 1'b1;
        for (int t = 0; t < 4; t++) send_word(tbl_s[t], tbl_e[t], 1'b1);
        repeat (2) @(negedge clk_b);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
